frame_sync_ctrl: RTL and testbench

FRAME_SYNC_CTRL -- requirements
Module: frame_sync_ctrl

---
 rtl/frame_sync_pkg.sv | 26 ++
 rtl/frame_sync_ctrl_if.sv | 17 +
 rtl/frame_sync_ctrl_fade_timer.sv | 42 ++++
 rtl/frame_sync_ctrl.sv | 79 +++++++
 tb/tb_frame_sync_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_sync_pkg.sv
// Shared types for the board update path: FSM states, board packing and fade defaults.
// Imported by the game logic, the frame sync controller and the renderer.
package frame_sync_pkg;
   localparam int NUM_CELLS = 16;
   localparam int CELL_W    = 4;
   localparam int GRID_W    = NUM_CELLS * CELL_W;
   localparam int CNT_W     = 3;
   localparam int PRE_W     = 4;
   localparam logic [CNT_W-1:0] FADE_START_DEF = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE, ST_PEND, ST_FADE, ST_FADE_PEND
   } fs_state_e;

   typedef struct packed {
      logic [GRID_W-1:0]    grid;
      logic [NUM_CELLS-1:0] mask;
   } fs_upd_t;

   // Cell n = {row, col} occupies bits [4n+3:4n].
   function automatic logic [CELL_W-1:0] get_cell(input logic [GRID_W-1:0] g,
                                                  input logic [1:0] row,
                                                  input logic [1:0] col);
      return g[{row, col}*CELL_W +: CELL_W];
   endfunction
endpackage

// File: rtl/frame_sync_ctrl_if.sv
// Update handshake from game logic plus the committed board seen by the renderer.
interface frame_sync_ctrl_if;
   import frame_sync_pkg::*;
   logic                 upd_valid;
   logic [GRID_W-1:0]    upd_grid;
   logic [NUM_CELLS-1:0] upd_new_tiles;
   logic                 upd_ready;
   logic [GRID_W-1:0]    grid;
   logic [NUM_CELLS-1:0] new_tiles;
   logic [CNT_W-1:0]     new_tiles_counter;
   logic                 busy;

   modport master (output upd_valid, upd_grid, upd_new_tiles,
                   input  upd_ready, grid, new_tiles, new_tiles_counter, busy);
   modport slave  (input  upd_valid, upd_grid, upd_new_tiles,
                   output upd_ready, grid, new_tiles, new_tiles_counter, busy);
endinterface

// File: rtl/frame_sync_ctrl_fade_timer.sv
// Frame prescaler plus fade-level down-counter; load wins over step, never wraps below 0.
module fade_timer
   import frame_sync_pkg::*;
#(
   parameter int STEP_FRAMES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             step_en,
   output logic [CNT_W-1:0] cnt,
   output logic             zero,
   output logic             expire
);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_FRAMES - 1);

   logic [PRE_W-1:0] pre;
   logic             wrap;

   assign wrap   = (pre == PRE_LAST);
   assign zero   = (cnt == '0);
   // Asserted on the edge where the level goes 1 -> 0.
   assign expire = step_en && wrap && (cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
         cnt <= '0;
      end else if (load) begin
         pre <= '0;
         cnt <= load_val;
      end else if (step_en && !zero) begin
         if (wrap) begin
            pre <= '0;
            cnt <= cnt - CNT_W'(1);
         end else begin
            pre <= pre + PRE_W'(1);
         end
      end
   end
endmodule

// File: rtl/frame_sync_ctrl.sv
// Buffers board updates from game logic and commits them to the renderer only at
// frame_start, then fades the new-tile highlight down over FADE_STEP_FRAMES per level.
module frame_sync_ctrl
   import frame_sync_pkg::*;
#(
   parameter int               FADE_STEP_FRAMES = 4,
   parameter logic [CNT_W-1:0] FADE_START       = FADE_START_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   frame_sync_ctrl_if.slave   bus
);
   fs_state_e            state, state_nxt;
   fs_upd_t              pend;
   logic [GRID_W-1:0]    grid_q;
   logic [NUM_CELLS-1:0] new_tiles_q;
   logic                 xfer, commit, mask_nz, step_en;
   logic [CNT_W-1:0]     t_cnt;
   logic                 t_zero, t_expire;

   assign bus.upd_ready = (state == ST_IDLE) || (state == ST_FADE);
   assign bus.busy      = (state != ST_IDLE);
   assign bus.grid      = grid_q;
   assign bus.new_tiles = new_tiles_q;
   assign bus.new_tiles_counter = t_cnt;

   assign xfer    = bus.upd_valid && bus.upd_ready;
   assign commit  = frame_start && ((state == ST_PEND) || (state == ST_FADE_PEND));
   assign mask_nz = |pend.mask;
   assign step_en = frame_start && (state == ST_FADE);

   fade_timer #(.STEP_FRAMES(FADE_STEP_FRAMES)) u_fade_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (commit),
      .load_val (mask_nz ? FADE_START : '0),
      .step_en  (step_en),
      .cnt      (t_cnt),
      .zero     (t_zero),
      .expire   (t_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (xfer) state_nxt = ST_PEND;
         ST_PEND:      if (frame_start) state_nxt = mask_nz ? ST_FADE : ST_IDLE;
         // A fade ending on the same edge as a transfer still hands over to PEND.
         ST_FADE: begin
            if (t_expire || t_zero) state_nxt = xfer ? ST_PEND : ST_IDLE;
            else if (xfer)          state_nxt = ST_FADE_PEND;
         end
         ST_FADE_PEND: if (frame_start) state_nxt = mask_nz ? ST_FADE : ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend        <= '0;
         grid_q      <= '0;
         new_tiles_q <= '0;
      end else begin
         if (xfer) pend <= '{grid: bus.upd_grid, mask: bus.upd_new_tiles};
         if (commit) begin
            grid_q      <= pend.grid;
            new_tiles_q <= pend.mask;
         end else if (t_expire) begin
            new_tiles_q <= '0;
         end
      end
   end
endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed checks of commit timing, fade stepping, abort/restart and async reset.
module tb_frame_sync_ctrl;
   import frame_sync_pkg::*;

   logic clk, rst_n, frame_start;
   int   tests_run, tests_failed;

   frame_sync_ctrl_if bus();

   frame_sync_ctrl #(.FADE_STEP_FRAMES(4), .FADE_START(3'd7)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .bus         (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic send_update(input logic [63:0] g, input logic [15:0] m);
      bus.upd_valid     = 1'b1;
      bus.upd_grid      = g;
      bus.upd_new_tiles = m;
      tick();
      bus.upd_valid     = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      frame_start = 1'b0;
      bus.upd_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      frame_start = 1'b0;
      bus.upd_valid = 1'b0;
      bus.upd_grid = '0;
      bus.upd_new_tiles = '0;
      #2;
      tests_run++;
      if (bus.grid !== 64'h0 || bus.new_tiles !== 16'h0 || bus.new_tiles_counter !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: grid=%h tiles=%h cnt=%0d, want 0", bus.grid, bus.new_tiles, bus.new_tiles_counter);
      end
      tests_run++;
      if (bus.upd_ready !== 1'b1 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: ready=%b busy=%b, want 1/0", bus.upd_ready, bus.busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
      pulse();
      tests_run++;
      if (bus.busy !== 1'b0 || bus.grid !== 64'h0 || bus.new_tiles_counter !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_idle_pulse: busy=%b grid=%h cnt=%0d, want 0", bus.busy, bus.grid, bus.new_tiles_counter);
      end
   endtask

   task automatic test_commit();
      send_update(64'h1, 16'h0001);
      tests_run++;
      if (bus.busy !== 1'b1 || bus.upd_ready !== 1'b0 || bus.grid !== 64'h0) begin
         tests_failed++;
         $display("FAIL commit_pend: busy=%b ready=%b grid=%h, want 1/0/0", bus.busy, bus.upd_ready, bus.grid);
      end
      repeat (5) tick();
      tests_run++;
      if (bus.grid !== 64'h0) begin
         tests_failed++;
         $display("FAIL commit_hold: grid=%h, want 0", bus.grid);
      end
      pulse();
      tests_run++;
      if (bus.grid !== 64'h1 || bus.new_tiles !== 16'h0001 || bus.new_tiles_counter !== 3'd7) begin
         tests_failed++;
         $display("FAIL commit_out: grid=%h tiles=%h cnt=%0d, want 1/0001/7", bus.grid, bus.new_tiles, bus.new_tiles_counter);
      end
      tests_run++;
      if (bus.busy !== 1'b1 || bus.upd_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL commit_flags: busy=%b ready=%b, want 1/1", bus.busy, bus.upd_ready);
      end
   endtask

   task automatic test_fade();
      for (int i = 1; i <= 28; i++) begin
         pulse();
         tick();
         tests_run++;
         if (bus.new_tiles_counter !== 3'(7 - i / 4)) begin
            tests_failed++;
            $display("FAIL fade_step_%0d: cnt=%0d, want %0d", i, bus.new_tiles_counter, 7 - i / 4);
         end
         if (i == 27) begin
            tests_run++;
            if (bus.new_tiles !== 16'h0001) begin
               tests_failed++;
               $display("FAIL fade_tiles_held: tiles=%h, want 0001", bus.new_tiles);
            end
         end
      end
      tests_run++;
      if (bus.new_tiles !== 16'h0 || bus.busy !== 1'b0 || bus.grid !== 64'h1) begin
         tests_failed++;
         $display("FAIL fade_end: tiles=%h busy=%b grid=%h, want 0/0/1", bus.new_tiles, bus.busy, bus.grid);
      end
   endtask

   task automatic test_empty_mask();
      send_update(64'hABCD, 16'h0000);
      pulse();
      tests_run++;
      if (bus.grid !== 64'hABCD || bus.new_tiles !== 16'h0 || bus.new_tiles_counter !== 3'd0) begin
         tests_failed++;
         $display("FAIL empty_out: grid=%h tiles=%h cnt=%0d, want abcd/0/0", bus.grid, bus.new_tiles, bus.new_tiles_counter);
      end
      tests_run++;
      if (bus.busy !== 1'b0 || bus.upd_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL empty_flags: busy=%b ready=%b, want 0/1", bus.busy, bus.upd_ready);
      end
   endtask

   task automatic test_abort();
      do_reset();
      send_update(64'hA, 16'h0001);
      pulse();
      repeat (8) pulse();
      send_update(64'hB, 16'h8000);
      tests_run++;
      if (bus.new_tiles_counter !== 3'd5 || bus.upd_ready !== 1'b0 || bus.grid !== 64'hA) begin
         tests_failed++;
         $display("FAIL abort_pend: cnt=%0d ready=%b grid=%h, want 5/0/a", bus.new_tiles_counter, bus.upd_ready, bus.grid);
      end
      tick();
      tick();
      tests_run++;
      if (bus.new_tiles_counter !== 3'd5) begin
         tests_failed++;
         $display("FAIL abort_hold: cnt=%0d, want 5", bus.new_tiles_counter);
      end
      pulse();
      tests_run++;
      if (bus.grid !== 64'hB || bus.new_tiles !== 16'h8000 || bus.new_tiles_counter !== 3'd7) begin
         tests_failed++;
         $display("FAIL abort_commit: grid=%h tiles=%h cnt=%0d, want b/8000/7", bus.grid, bus.new_tiles, bus.new_tiles_counter);
      end
      pulse();
      pulse();
      tests_run++;
      if (bus.new_tiles_counter !== 3'd7 || bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_restart: cnt=%0d busy=%b, want 7/1", bus.new_tiles_counter, bus.busy);
      end
   endtask

   task automatic test_coincident_idle();
      do_reset();
      bus.upd_valid = 1'b1;
      bus.upd_grid = 64'hC;
      bus.upd_new_tiles = 16'h0010;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      bus.upd_grid = 64'hD;
      bus.upd_new_tiles = 16'h0020;
      tests_run++;
      if (bus.grid !== 64'h0 || bus.busy !== 1'b1 || bus.upd_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL coin_idle_pend: grid=%h busy=%b ready=%b, want 0/1/0", bus.grid, bus.busy, bus.upd_ready);
      end
      tick();
      tick();
      pulse();
      bus.upd_valid = 1'b0;
      tests_run++;
      if (bus.grid !== 64'hC || bus.new_tiles !== 16'h0010 || bus.new_tiles_counter !== 3'd7) begin
         tests_failed++;
         $display("FAIL coin_idle_commit: grid=%h tiles=%h cnt=%0d, want c/0010/7", bus.grid, bus.new_tiles, bus.new_tiles_counter);
      end
   endtask

   task automatic test_coincident_fade();
      do_reset();
      send_update(64'h2, 16'h0002);
      pulse();
      repeat (3) pulse();
      bus.upd_valid = 1'b1;
      bus.upd_grid = 64'h3;
      bus.upd_new_tiles = 16'h0004;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      bus.upd_valid = 1'b0;
      tests_run++;
      if (bus.new_tiles_counter !== 3'd6 || bus.grid !== 64'h2 || bus.upd_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL coin_fade_step: cnt=%0d grid=%h ready=%b, want 6/2/0", bus.new_tiles_counter, bus.grid, bus.upd_ready);
      end
      pulse();
      tests_run++;
      if (bus.grid !== 64'h3 || bus.new_tiles !== 16'h0004 || bus.new_tiles_counter !== 3'd7) begin
         tests_failed++;
         $display("FAIL coin_fade_commit: grid=%h tiles=%h cnt=%0d, want 3/0004/7", bus.grid, bus.new_tiles, bus.new_tiles_counter);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      send_update(64'h5, 16'h0001);
      pulse();
      repeat (12) pulse();
      send_update(64'hE, 16'h0001);
      tests_run++;
      if (bus.new_tiles_counter !== 3'd4 || bus.upd_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL areset_setup: cnt=%0d ready=%b, want 4/0", bus.new_tiles_counter, bus.upd_ready);
      end
      #3;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.grid !== 64'h0 || bus.new_tiles !== 16'h0 || bus.new_tiles_counter !== 3'd0 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL areset_async: grid=%h tiles=%h cnt=%0d busy=%b, want 0", bus.grid, bus.new_tiles, bus.new_tiles_counter, bus.busy);
      end
      #2;
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (bus.upd_ready !== 1'b1 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL areset_release: ready=%b busy=%b, want 1/0", bus.upd_ready, bus.busy);
      end
      pulse();
      tests_run++;
      if (bus.grid !== 64'h0 || bus.new_tiles_counter !== 3'd0 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL areset_buf_lost: grid=%h cnt=%0d busy=%b, want 0/0/0", bus.grid, bus.new_tiles_counter, bus.busy);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_commit();
      test_fade();
      test_empty_mask();
      test_abort();
      test_coincident_idle();
      test_coincident_fade();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
